peridot_i2c_eeprom_reader: RTL and testbench

- I2C initiator that performs EEPROM random-address sequential reads: START, devsel+W, word address, repeated START, devsel+R, N data bytes, NACK on last byte, STOP.
- Counterpart to the board serial-ROM responder. Boot and ID logic use it to fetch board data over the open-drain I2C pins.
- Bytes stream out one at a time with a valid strobe. No internal buffer.

---
 rtl/peridot_i2c_eeprom_reader.sv | 209 ++++++++++++++++++++
 tb/tb_peridot_i2c_eeprom_reader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/peridot_i2c_eeprom_reader.sv
// I2C initiator for EEPROM random-address sequential reads (devsel+W, word addr,
// repeated START, devsel+R, N bytes). Bytes stream out on rdata/rdata_valid.
module peridot_i2c_eeprom_reader #(
    parameter logic [6:0] DEVICE_ADDRESS = 7'b1010000,
    parameter int         CLOCK_DIVIDE   = 63
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] start_addr,
    input  logic [4:0] read_length,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    input  logic       i2c_scl_i,
    output logic       i2c_scl_o,
    input  logic       i2c_sda_i,
    output logic       i2c_sda_o
);
    localparam logic [9:0] DIV_MAX = 10'(CLOCK_DIVIDE);

    typedef enum logic [3:0] {
        IDLE, START, DEVSEL_W, ACK1, ADDR, ACK2, RESTART,
        DEVSEL_R, ACK3, READ, MACK, STOP
    } state_t;

    state_t     state;
    logic [9:0] div;
    logic [1:0] phase;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] addr_q;
    logic [4:0] remaining;
    logic       nack;
    logic       accept, hold, tick;
    logic       scl_nxt, sda_nxt;
    logic [3:0] seq;

    // A start landing on the done cycle is dropped as well as one while busy.
    assign accept = start && !busy && !done;
    // Target stretching: freeze the divider while SCL is released but still low.
    assign hold   = (phase == 2'd2) && i2c_scl_o && !i2c_scl_i;
    assign tick   = busy && !hold && (div == DIV_MAX);
    // START/RESTART/STOP are four frames long; seq indexes their 16 quarters.
    assign seq    = {bit_cnt[1:0], phase};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            div <= '0;
        else if (accept || hold || tick)
            div <= '0;
        else if (busy)
            div <= div + 10'd1;
    end

    always_comb begin
        scl_nxt = 1'b1;
        sda_nxt = 1'b1;
        case (state)
            START: begin
                scl_nxt = (seq < 4'd12);
                sda_nxt = (seq < 4'd8);
            end
            RESTART: begin
                scl_nxt = (seq >= 4'd4) && (seq < 4'd12);
                sda_nxt = (seq < 4'd8);
            end
            STOP: begin
                scl_nxt = (seq >= 4'd4);
                sda_nxt = (seq == 4'd0) || (seq >= 4'd8);
            end
            DEVSEL_W, ADDR, DEVSEL_R: begin
                scl_nxt = phase[1];
                sda_nxt = shreg[7];
            end
            MACK: begin
                scl_nxt = phase[1];
                sda_nxt = (remaining == 5'd0);
            end
            ACK1, ACK2, ACK3, READ: begin
                scl_nxt = phase[1];
                sda_nxt = 1'b1;
            end
            default: begin
                scl_nxt = 1'b1;
                sda_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i2c_scl_o <= 1'b1;
            i2c_sda_o <= 1'b1;
        end else begin
            i2c_scl_o <= scl_nxt;
            i2c_sda_o <= sda_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            phase       <= 2'd0;
            bit_cnt     <= 3'd0;
            shreg       <= 8'h00;
            addr_q      <= 8'h00;
            remaining   <= 5'd0;
            nack        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            rdata       <= 8'h00;
            rdata_valid <= 1'b0;
        end else begin
            done        <= 1'b0;
            rdata_valid <= 1'b0;
            if (accept) begin
                state     <= START;
                phase     <= 2'd0;
                bit_cnt   <= 3'd0;
                addr_q    <= start_addr;
                remaining <= read_length;
                error     <= 1'b0;
                busy      <= 1'b1;
            end else if (tick) begin
                phase <= phase + 2'd1;
                // SDA is sampled on the tick that closes the SCL-high quarter
                if (phase == 2'd2) begin
                    nack <= i2c_sda_i;
                    if (state == READ) begin
                        shreg <= {shreg[6:0], i2c_sda_i};
                        if (bit_cnt == 3'd7) begin
                            rdata       <= {shreg[6:0], i2c_sda_i};
                            rdata_valid <= 1'b1;
                        end
                    end
                end
                if (phase == 2'd3) begin
                    case (state)
                        START: begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd3) begin
                                state   <= DEVSEL_W;
                                bit_cnt <= 3'd0;
                                shreg   <= {DEVICE_ADDRESS, 1'b0};
                            end
                        end
                        RESTART: begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd3) begin
                                state   <= DEVSEL_R;
                                bit_cnt <= 3'd0;
                                shreg   <= {DEVICE_ADDRESS, 1'b1};
                            end
                        end
                        DEVSEL_W, ADDR, DEVSEL_R: begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= {shreg[6:0], 1'b0};
                            if (bit_cnt == 3'd7)
                                state <= (state == DEVSEL_W) ? ACK1 :
                                         (state == ADDR)     ? ACK2 : ACK3;
                        end
                        ACK1, ACK2, ACK3: begin
                            bit_cnt <= 3'd0;
                            if (nack) begin
                                error <= 1'b1;
                                state <= STOP;
                            end else if (state == ACK1) begin
                                state <= ADDR;
                                shreg <= addr_q;
                            end else if (state == ACK2) begin
                                state <= RESTART;
                            end else begin
                                state <= READ;
                            end
                        end
                        READ: begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                state <= MACK;
                        end
                        MACK: begin
                            bit_cnt <= 3'd0;
                            if (remaining == 5'd0) begin
                                state <= STOP;
                            end else begin
                                remaining <= remaining - 5'd1;
                                state     <= READ;
                            end
                        end
                        STOP: begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd3) begin
                                state   <= IDLE;
                                bit_cnt <= 3'd0;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_peridot_i2c_eeprom_reader.sv
// Bench for peridot_i2c_eeprom_reader: behavioural EEPROM target on the
// open-drain bus, table of read transactions plus hand-written corner sequences.
module tb_peridot_i2c_eeprom_reader;
    localparam int CD = 3;
    localparam int SL_IDLE = 0, SL_DEV = 1, SL_WORD = 2, SL_TX = 3, SL_IGN = 4;

    logic       clk = 1'b0, reset_n = 1'b0, start = 1'b0;
    logic [7:0] start_addr = 8'h00;
    logic [4:0] read_length = 5'd0;
    logic       busy, done, error, rdata_valid, scl_o, sda_o;
    logic [7:0] rdata;
    logic       s_scl = 1'b1, s_sda = 1'b1;
    wire        scl_bus = scl_o & s_scl;
    wire        sda_bus = sda_o & s_sda;

    peridot_i2c_eeprom_reader #(.DEVICE_ADDRESS(7'h50), .CLOCK_DIVIDE(CD)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
        .read_length(read_length), .busy(busy), .done(done), .error(error),
        .rdata(rdata), .rdata_valid(rdata_valid),
        .i2c_scl_i(scl_bus), .i2c_scl_o(scl_o), .i2c_sda_i(sda_bus), .i2c_sda_o(sda_o));

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    // ---- target model ----
    int         st = SL_IDLE, bitn = 0, mem_mode = 0, stretch_cnt = 0;
    int         n_start = 0, n_stop = 0, sda_chg_stretch = 0, done_cnt = 0;
    bit         stretch_en = 0, stretching = 0, sl_reset = 0;
    logic [6:0] sl_addr = 7'h50;
    logic [8:0] sh9 = 9'h0;
    logic [7:0] tx = 8'h0, ptr = 8'h0;
    logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_sda_o = 1'b1;
    logic [8:0] trace[$];
    logic [7:0] rq[$];

    function automatic logic [7:0] memv(input logic [7:0] a);
        return (mem_mode == 1 && a == 8'h10) ? 8'h5A : (a ^ 8'hFF);
    endfunction

    always @(negedge clk) begin
        logic scl, sda;
        if (rdata_valid) rq.push_back(rdata);
        if (done) done_cnt++;
        if (sl_reset) begin
            s_scl = 1'b1; s_sda = 1'b1; st = SL_IDLE; bitn = 0; stretching = 0;
        end
        if (stretching && sda_o != prev_sda_o) sda_chg_stretch++;
        if (stretching) begin
            if (scl_o) stretch_cnt++;
            if (stretch_cnt >= 50) begin s_scl = 1'b1; stretching = 0; end
        end
        scl = scl_o & s_scl;
        sda = sda_o & s_sda;
        if (prev_scl && scl && prev_sda && !sda) begin
            n_start++; st = SL_DEV; bitn = 0; s_sda = 1'b1;
        end else if (prev_scl && scl && !prev_sda && sda) begin
            n_stop++; st = SL_IDLE; s_sda = 1'b1;
        end else if (!prev_scl && scl) begin
            sh9 = {sh9[7:0], sda};
            bitn++;
            if (bitn == 9) trace.push_back(sh9);
        end else if (prev_scl && !scl) begin
            if (bitn == 8) begin
                case (st)
                    SL_DEV:  s_sda = (sh9[7:1] != sl_addr);
                    SL_WORD: begin
                        s_sda = 1'b0;
                        if (stretch_en) begin s_scl = 1'b0; stretching = 1; stretch_cnt = 0; end
                    end
                    SL_TX:   s_sda = 1'b1;
                    default: s_sda = 1'b1;
                endcase
            end else if (bitn == 9) begin
                bitn = 0;
                case (st)
                    SL_DEV: begin
                        if (sh9[8:2] != sl_addr) begin st = SL_IGN; s_sda = 1'b1; end
                        else if (sh9[1]) begin st = SL_TX; tx = memv(ptr); s_sda = tx[7]; end
                        else begin st = SL_WORD; s_sda = 1'b1; end
                    end
                    SL_WORD: begin ptr = sh9[8:1]; st = SL_IGN; s_sda = 1'b1; end
                    SL_TX: begin
                        if (!sh9[0]) begin ptr = ptr + 8'd1; tx = memv(ptr); s_sda = tx[7]; end
                        else begin st = SL_IGN; s_sda = 1'b1; end
                    end
                    default: s_sda = 1'b1;
                endcase
            end else if (st == SL_TX && bitn >= 1 && bitn <= 7) begin
                s_sda = tx[7 - bitn];
            end
        end
        prev_scl   = scl_o & s_scl;
        prev_sda   = sda_o & s_sda;
        prev_sda_o = sda_o;
    end

    // ---- transaction table ----
    typedef struct {
        logic [6:0] dev;
        logic [7:0] addr;
        logic [4:0] len;
        int         mode;
        bit         stretch;
        bit         exp_err;
        int         exp_cnt;
        logic [7:0] exp_first;
        logic [7:0] exp_last;
        int         cyc_lo;
        int         cyc_hi;
    } vec_t;
    vec_t vt[5];

    task automatic clear_obs();
        trace.delete(); rq.delete();
        n_start = 0; n_stop = 0; sda_chg_stretch = 0; done_cnt = 0;
    endtask

    task automatic wait_done(input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int t0, t1, exp_tr;
        bit ok;
        logic [7:0] a;
        sl_addr = v.dev; mem_mode = v.mode; stretch_en = v.stretch;
        clear_obs();
        @(negedge clk);
        start = 1'b1; start_addr = v.addr; read_length = v.len;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        chk({tag, "_busy"}, busy, 1);
        wait_done(8000, ok);
        t1 = cyc;
        chk({tag, "_done_seen"}, ok, 1);
        chk({tag, "_error"}, error, v.exp_err);
        chk({tag, "_busy_at_done"}, busy, 0);
        chk_rng({tag, "_latency"}, t1 - t0, v.cyc_lo, v.cyc_hi);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_error_held"}, error, v.exp_err);
        chk({tag, "_nbytes"}, rq.size(), v.exp_cnt);
        if (v.exp_cnt > 0 && rq.size() == v.exp_cnt) begin
            chk({tag, "_first"}, rq[0], v.exp_first);
            chk({tag, "_last"}, rq[v.exp_cnt - 1], v.exp_last);
            for (int i = 0; i < v.exp_cnt; i++) begin
                a = v.addr + 8'(i);
                chk({tag, "_byte"}, rq[i], memv(a));
            end
        end
        exp_tr = v.exp_err ? 1 : 4 + int'(v.len);
        chk({tag, "_trace_len"}, trace.size(), exp_tr);
        if (trace.size() == exp_tr) begin
            chk({tag, "_devsel_w"}, trace[0], {8'hA0, v.exp_err});
            if (!v.exp_err) begin
                chk({tag, "_word_addr"}, trace[1], {v.addr, 1'b0});
                chk({tag, "_devsel_r"}, trace[2], {8'hA1, 1'b0});
                for (int i = 0; i <= int'(v.len); i++)
                    chk({tag, "_master_ack"}, trace[3 + i][0], (i == int'(v.len)) ? 1 : 0);
            end
        end
        chk({tag, "_n_start"}, n_start, v.exp_err ? 1 : 2);
        chk({tag, "_n_stop"}, n_stop, 1);
        chk({tag, "_sda_quiet_stretch"}, sda_chg_stretch, 0);
    endtask

    initial begin
        bit ok;
        //           dev    addr   len  mode str err cnt first  last   lo    hi
        vt[0] = '{7'h50, 8'h10, 5'd0,  1, 0, 0, 1,  8'h5A, 8'h5A, 766,  770};
        vt[1] = '{7'h50, 8'h00, 5'd31, 0, 0, 0, 32, 8'hFF, 8'hE0, 5230, 5234};
        vt[2] = '{7'h51, 8'h10, 5'd3,  0, 0, 1, 0,  8'h00, 8'h00, 270,  274};
        vt[3] = '{7'h50, 8'hF0, 5'd3,  0, 1, 0, 4,  8'h0F, 8'h0C, 1250, 1256};
        vt[4] = '{7'h50, 8'h7E, 5'd2,  0, 0, 0, 3,  8'h81, 8'h7F, 1054, 1058};

        // reset hold with toggling inputs
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = 1'($urandom); start_addr = 8'($urandom); read_length = 5'($urandom);
            @(negedge clk);
            chk("rst_scl", scl_o, 1);
            chk("rst_sda", sda_o, 1);
            chk("rst_busy", busy, 0);
        end
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_rvalid", rdata_valid, 0);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // second start while busy, then start on the done cycle
        sl_addr = 7'h50; mem_mode = 1; stretch_en = 0;
        clear_obs();
        @(negedge clk);
        start = 1'b1; start_addr = 8'h10; read_length = 5'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        start = 1'b1; start_addr = 8'h33; read_length = 5'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(8000, ok);
        chk("dbl_done_seen", ok, 1);
        start = 1'b1; start_addr = 8'h44; read_length = 5'd1;
        @(negedge clk);
        start = 1'b0;
        chk("done_cycle_start_busy", busy, 0);
        repeat (20) @(negedge clk);
        chk("done_cycle_start_idle", busy, 0);
        chk("dbl_trace_len", trace.size(), 4);
        if (trace.size() == 4) chk("dbl_word_addr", trace[1], {8'h10, 1'b0});
        chk("dbl_nbytes", rq.size(), 1);
        chk("dbl_n_start", n_start, 2);
        chk("dbl_n_done", done_cnt, 1);

        // reset mid-READ
        sl_addr = 7'h50; mem_mode = 0;
        clear_obs();
        @(negedge clk);
        start = 1'b1; start_addr = 8'h00; read_length = 5'd31;
        @(negedge clk);
        start = 1'b0;
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (rq.size() >= 3) begin ok = 1; break; end
        end
        chk("midrd_reached", ok, 1);
        repeat (7) @(negedge clk);
        reset_n = 1'b0; sl_reset = 1;
        #1;
        chk("midrd_scl_rel", scl_o, 1);
        chk("midrd_sda_rel", sda_o, 1);
        chk("midrd_busy", busy, 0);
        repeat (4) @(negedge clk);
        reset_n = 1'b1; sl_reset = 0;
        done_cnt = 0;
        repeat (300) @(negedge clk);
        chk("midrd_no_done", done_cnt, 0);
        chk("midrd_idle", busy, 0);
        run_vec(vt[0], "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
